devil_snoop_ctrl: RTL and testbench
===================================

// Module: devil_snoop_ctrl
// PURPOSE
// ACE snoop-channel manipulator with AXI4-Lite CSR and AXI4 read master. Intercepts AC requests,
// returns CR responses with programmable delay/response, filtered by snoop type and address
// window, in one-shot or continuous mode. Also leaks 4 memory words into CSRs via AXI4 read.
// PARAMETERS
// AC_ADDR_W 44 ACE snoop address width;  M_ADDR_W 32 read-master address width;  DATA_W 32 (fixed)
// PORTS
// clk_100MHz     in   1   sole clock
// reset          in   1   asynchronous, active-high
// acvalid/acready in/out 1/1 AC handshake;  acaddr in AC_ADDR_W;  acsnoop in 4
// crvalid/crready out/in 1/1 CR handshake;  crresp out 5
// s_axi_aw{addr[5:0],valid}/awready in/out; s_axi_w{data[31:0],strb[3:0],valid}/wready in/out
// s_axi_b{resp[1:0],valid} out, bready in; s_axi_ar{addr[5:0],valid}/arready in/out
// s_axi_r{data[31:0],resp[1:0],valid} out, rready in   (AXI4-Lite CSR slave)
// m_axi_ar{addr[31:0],len[7:0],size[2:0],burst[1:0],valid} out, arready in (AXI4 read master)
// m_axi_r{data[31:0],resp[1:0],last,valid} in, rready out
// BEHAVIOUR
// Reset: all CSRs 0; acready=1, crvalid=0, crresp=0, all AXI valids 0, rready 0, FSMs idle.
// CSRs: 0x00 CTRL RW; 0x04 STATUS W1C; 0x08 DELAY RW; 0x0C ACSNOOP RW; 0x10 BASE_ADDR RW;
//   0x14 MEM_SIZE RW; 0x18..0x24 RDATA1..4 RO. Unmapped reads 0; RO/unmapped writes ignored;
//   bresp/rresp always OKAY; wstrb honoured. AW and W accepted together, one transfer at a time.
// CTRL: [0]EN [4:1]TEST(0 FUZZ,1 DELAY_CR,2 DELAY_CD,3 DELAY_CL) [8:5]FUNC(0 OSH,1 CON)
//   [13:9]CRRESP [14]ACFLT [15]ADDRFLT [16]OSHEN [17]CONEN [31:18] stored, read back, unused.
// STATUS: [0] one-shot done, [1] leak done; write 1 clears bit; set has priority over clear.
// Match = (!ACFLT | acsnoop==ACSNOOP[3:0]) & (!ADDRFLT | (acaddr[43:32]==0 &
//   BASE_ADDR<=acaddr[31:0] < BASE_ADDR+MEM_SIZE, 33-bit sum)); MEM_SIZE=0 never matches.
// Attack = EN & TEST==DELAY_CR & match & ((FUNC==OSH & OSHEN & !STATUS[0]) | (FUNC==CON & CONEN)).
// Snoop FSM: IDLE(acready=1) -AC handshake-> WAIT -> RESP(crvalid=1 until crready) -> IDLE.
//   Attack: WAIT holds DELAY cycles (0 = straight to RESP next cycle), crresp=CTRL[13:9];
//   FUNC OSH sets STATUS[0] on CR handshake. Non-attack: RESP next cycle, crresp=0.
//   acready=0 outside IDLE; crresp stable while crvalid; CTRL changes mid-snoop take effect
//   at next AC handshake. EN=0 or other TEST/FUNC values: passthrough.
// Leak FSM: EN rising edge with TEST==FUZZ -> issue araddr={BASE_ADDR[31:2],2'b0}, arlen=3,
//   arsize=2, arburst=INCR; hold arvalid until arready; rready=1; beats 0..3 -> RDATA1..4;
//   on rlast set STATUS[1], idle. Non-OKAY rresp still stores data. EN falling mid-burst
//   does not abort burst. RDATA holds last values until next leak.
// Reset asserted mid-operation: immediate return to reset state, outstanding beats dropped.
// TESTING
// BASE_ADDR=0x2, MEM_SIZE=0, CTRL=0x1, wait 100ns, CTRL=0 -> one AR at 0x0 len 3;
//   RDATA1..4 equal memory words 0x0,0x4,0x8,0xC; STATUS[1]=1.
// DELAY=2, CTRL=TEST1|OSH|OSHEN|EN -> first snoop crvalid 3 cycles after AC handshake, STATUS=1;
//   later snoops respond next cycle; write STATUS=1 -> STATUS=0.
// CTRL=TEST1|CON|CONEN|EN|CRRESP=5, DELAY=0 -> every snoop crvalid next cycle with crresp=5;
//   EN=0 -> crresp=0.
// ACFLT, ACSNOOP=1: acsnoop=0 -> passthrough (crresp 0); acsnoop=1 -> attacked.
// ADDRFLT, BASE=0x10 SIZE=0x100: acaddr 0x0/0x110 pass through; 0x10, 0x10F attacked.
// crready held low 5 cycles -> crvalid/crresp stable, acready=0 throughout; reset mid-WAIT -> idle.

Source files
------------

// File: rtl/devil_snoop_ctrl.sv
// rtl/devil_snoop_ctrl.sv - ACE snoop-response manipulator with AXI4-Lite CSRs and a 4-beat AXI4 leak reader
// Delays/rewrites CR responses for matching AC snoops; copies four memory words into read-only CSRs.
module devil_snoop_ctrl #(
  parameter int AC_ADDR_W = 44,
  parameter int M_ADDR_W  = 32,
  parameter int DATA_W    = 32
) (
  input  logic                 clk_100MHz,
  input  logic                 reset,
  input  logic                 acvalid,
  output logic                 acready,
  input  logic [AC_ADDR_W-1:0] acaddr,
  input  logic [3:0]           acsnoop,
  output logic                 crvalid,
  input  logic                 crready,
  output logic [4:0]           crresp,
  input  logic [5:0]           s_axi_awaddr,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [DATA_W-1:0]    s_axi_wdata,
  input  logic [DATA_W/8-1:0]  s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [5:0]           s_axi_araddr,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [DATA_W-1:0]    s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic [M_ADDR_W-1:0]  m_axi_araddr,
  output logic [7:0]           m_axi_arlen,
  output logic [2:0]           m_axi_arsize,
  output logic [1:0]           m_axi_arburst,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic [DATA_W-1:0]    m_axi_rdata,
  input  logic [1:0]           m_axi_rresp,
  input  logic                 m_axi_rlast,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} snoop_state_t;
  typedef enum logic [1:0] {L_IDLE, L_AR, L_R} leak_state_t;

  snoop_state_t         s_state, s_next;
  leak_state_t          l_state, l_next;

  logic [31:0]          ctrl_q, delay_q, acsnoop_q, base_q, size_q;
  logic [1:0]           status_q;
  logic [31:0]          leak_q [4];
  logic [31:0]          cnt_q;
  logic [4:0]           resp_q;
  logic                 osh_q;
  logic                 en_q;
  logic [1:0]           beat_q;
  logic [M_ADDR_W-1:0]  leak_addr_q;
  logic                 bvalid_q, rvalid_q;
  logic [31:0]          rdata_q;

  logic [31:0]          wmask, rd_word;
  logic                 wr_fire, rd_fire;
  logic [1:0]           status_set, status_clr;
  logic [3:0]           test, func;
  logic [32:0]          ac_lo, win_hi;
  logic                 addr_hit, match, attack;
  logic                 ac_hs, cr_hs, en_rise, leak_done;
  logic                 unused_rresp;

  // Response status of leak beats is deliberately ignored; data is stored regardless.
  assign unused_rresp = &{1'b0, m_axi_rresp};

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] nw,
                                        input logic [31:0] m);
    return (cur & ~m) | (nw & m);
  endfunction

  assign test     = ctrl_q[4:1];
  assign func     = ctrl_q[8:5];
  assign ac_lo    = {1'b0, acaddr[31:0]};
  assign win_hi   = {1'b0, base_q} + {1'b0, size_q};
  assign addr_hit = (acaddr[AC_ADDR_W-1:32] == '0) && (ac_lo >= {1'b0, base_q}) && (ac_lo < win_hi);
  assign match    = (!ctrl_q[14] || (acsnoop == acsnoop_q[3:0])) && (!ctrl_q[15] || addr_hit);
  assign attack   = ctrl_q[0] && (test == 4'd1) && match &&
                    (((func == 4'd0) && ctrl_q[16] && !status_q[0]) || ((func == 4'd1) && ctrl_q[17]));

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) s_state <= S_IDLE;
    else       s_state <= s_next;
  end

  always_comb begin
    s_next  = s_state;
    acready = 1'b0;
    crvalid = 1'b0;
    case (s_state)
      S_IDLE: begin
        acready = 1'b1;
        if (acvalid) s_next = S_WAIT;
      end
      S_WAIT: if (cnt_q == '0) s_next = S_RESP;
      S_RESP: begin
        crvalid = 1'b1;
        if (crready) s_next = S_IDLE;
      end
      default: s_next = S_IDLE;
    endcase
  end

  assign ac_hs  = acvalid && acready;
  assign cr_hs  = crvalid && crready;
  assign crresp = resp_q;

  // Attack decision and response code are frozen at the AC handshake.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      resp_q <= '0;
      osh_q  <= 1'b0;
    end else if (ac_hs) begin
      cnt_q  <= attack ? delay_q : 32'd0;
      resp_q <= attack ? ctrl_q[13:9] : 5'd0;
      osh_q  <= attack && (func == 4'd0);
    end else if ((s_state == S_WAIT) && (cnt_q != '0)) begin
      cnt_q  <= cnt_q - 32'd1;
    end
  end

  assign en_rise = ctrl_q[0] && !en_q && (test == 4'd0);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) l_state <= L_IDLE;
    else       l_state <= l_next;
  end

  always_comb begin
    l_next        = l_state;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    leak_done     = 1'b0;
    case (l_state)
      L_IDLE: if (en_rise) l_next = L_AR;
      L_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) l_next = L_R;
      end
      L_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && m_axi_rlast) begin
          leak_done = 1'b1;
          l_next    = L_IDLE;
        end
      end
      default: l_next = L_IDLE;
    endcase
  end

  assign m_axi_araddr  = leak_addr_q;
  assign m_axi_arlen   = 8'd3;
  assign m_axi_arsize  = 3'd2;
  assign m_axi_arburst = 2'b01;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      en_q        <= 1'b0;
      beat_q      <= '0;
      leak_addr_q <= '0;
      for (int i = 0; i < 4; i++) leak_q[i] <= '0;
    end else begin
      en_q <= ctrl_q[0];
      if ((l_state == L_IDLE) && en_rise) begin
        leak_addr_q <= {base_q[M_ADDR_W-1:2], 2'b00};
        beat_q      <= '0;
      end else if ((l_state == L_R) && m_axi_rvalid) begin
        leak_q[beat_q] <= m_axi_rdata;
        beat_q         <= beat_q + 2'd1;
      end
    end
  end

  assign wmask         = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}}, {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
  assign wr_fire       = s_axi_awvalid && s_axi_wvalid && !bvalid_q;
  assign s_axi_awready = wr_fire;
  assign s_axi_wready  = wr_fire;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign status_set    = {leak_done, cr_hs && osh_q};
  assign status_clr    = (wr_fire && (s_axi_awaddr == 6'h04)) ? (s_axi_wdata[1:0] & wmask[1:0]) : 2'b00;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      ctrl_q    <= '0;
      delay_q   <= '0;
      acsnoop_q <= '0;
      base_q    <= '0;
      size_q    <= '0;
      status_q  <= '0;
      bvalid_q  <= 1'b0;
    end else begin
      status_q <= (status_q & ~status_clr) | status_set;
      if (wr_fire) begin
        case (s_axi_awaddr)
          6'h00:   ctrl_q    <= merge(ctrl_q, s_axi_wdata, wmask);
          6'h08:   delay_q   <= merge(delay_q, s_axi_wdata, wmask);
          6'h0C:   acsnoop_q <= merge(acsnoop_q, s_axi_wdata, wmask);
          6'h10:   base_q    <= merge(base_q, s_axi_wdata, wmask);
          6'h14:   size_q    <= merge(size_q, s_axi_wdata, wmask);
          default: ;
        endcase
      end
      if (wr_fire)           bvalid_q <= 1'b1;
      else if (s_axi_bready) bvalid_q <= 1'b0;
    end
  end

  always_comb begin
    rd_word = '0;
    case (s_axi_araddr)
      6'h00:   rd_word = ctrl_q;
      6'h04:   rd_word = {30'd0, status_q};
      6'h08:   rd_word = delay_q;
      6'h0C:   rd_word = acsnoop_q;
      6'h10:   rd_word = base_q;
      6'h14:   rd_word = size_q;
      6'h18:   rd_word = leak_q[0];
      6'h1C:   rd_word = leak_q[1];
      6'h20:   rd_word = leak_q[2];
      6'h24:   rd_word = leak_q[3];
      default: rd_word = '0;
    endcase
  end

  assign rd_fire       = s_axi_arvalid && !rvalid_q;
  assign s_axi_arready = !rvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (rd_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_word;
    end else if (s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_devil_snoop_ctrl.sv
// tb/tb_devil_snoop_ctrl.sv - directed and randomized checks of devil_snoop_ctrl against a behavioural model
// Includes a randomly-stalling AXI4 memory slave for the leak reader.
module tb_devil_snoop_ctrl;

  logic        clk_100MHz = 0;
  logic        reset = 1;
  logic        acvalid = 0, acready;
  logic [43:0] acaddr = '0;
  logic [3:0]  acsnoop = '0;
  logic        crvalid, crready = 0;
  logic [4:0]  crresp;
  logic [5:0]  s_axi_awaddr = '0, s_axi_araddr = '0;
  logic        s_axi_awvalid = 0, s_axi_awready, s_axi_wvalid = 0, s_axi_wready;
  logic [31:0] s_axi_wdata = '0, s_axi_rdata;
  logic [3:0]  s_axi_wstrb = '0;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready = 1, s_axi_arvalid = 0, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready = 1;
  logic [31:0] m_axi_araddr, m_axi_rdata;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst, m_axi_rresp;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;

  int n_cmp = 0, n_err = 0;

  devil_snoop_ctrl dut (
    .clk_100MHz(clk_100MHz), .reset(reset),
    .acvalid(acvalid), .acready(acready), .acaddr(acaddr), .acsnoop(acsnoop),
    .crvalid(crvalid), .crready(crready), .crresp(crresp),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #800us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory slave: random AR/R stalls, beat 1 returns SLVERR.
  logic [31:0] mem [64];
  int          ar_count = 0;
  logic [31:0] ar_addr_seen = '0, cap_addr = '0;
  logic [7:0]  ar_len_seen = '0, cap_len = '0;
  logic [2:0]  ar_size_seen = '0, cap_size = '0;
  logic [1:0]  ar_burst_seen = '0, cap_burst = '0;
  bit          sl_busy = 0, ar_seen = 0, r_seen = 0;
  int          sl_beat = 0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
    forever begin
      @(negedge clk_100MHz);
      if (reset) begin
        sl_busy = 0; sl_beat = 0; ar_seen = 0; r_seen = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
      end else begin
        if (ar_seen) begin
          ar_count++;
          ar_addr_seen = cap_addr; ar_len_seen = cap_len;
          ar_size_seen = cap_size; ar_burst_seen = cap_burst;
          sl_busy = 1; sl_beat = 0;
        end
        if (r_seen) begin
          sl_beat++;
          if (sl_beat == 4) sl_busy = 0;
        end
        m_axi_arready = !sl_busy && ($urandom_range(0, 1) == 1);
        if (sl_busy && $urandom_range(0, 3) != 0) begin
          m_axi_rvalid = 1;
          m_axi_rdata  = mem[((ar_addr_seen >> 2) + sl_beat) & 63];
          m_axi_rlast  = (sl_beat == 3);
          m_axi_rresp  = (sl_beat == 1) ? 2'b10 : 2'b00;
        end else begin
          m_axi_rvalid = 0;
          m_axi_rlast  = 0;
        end
        ar_seen   = m_axi_arvalid && m_axi_arready;
        cap_addr  = m_axi_araddr; cap_len = m_axi_arlen;
        cap_size  = m_axi_arsize; cap_burst = m_axi_arburst;
        r_seen    = m_axi_rvalid && m_axi_rready;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic csr_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] st = 4'hF);
    int n = 0;
    @(negedge clk_100MHz);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = st;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    while (!s_axi_awready && n < 50) begin @(negedge clk_100MHz); n++; end
    @(negedge clk_100MHz);
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    chk("csr_wr_bvalid", s_axi_bvalid, 1'b1);
    chk("csr_wr_bresp", s_axi_bresp, 2'b00);
  endtask

  task automatic csr_rd(input logic [5:0] a, output logic [31:0] d);
    int n = 0;
    @(negedge clk_100MHz);
    s_axi_araddr = a; s_axi_arvalid = 1;
    while (!s_axi_arready && n < 50) begin @(negedge clk_100MHz); n++; end
    @(negedge clk_100MHz);
    s_axi_arvalid = 0;
    n = 0;
    while (!s_axi_rvalid && n < 50) begin @(negedge clk_100MHz); n++; end
    chk("csr_rd_rresp", s_axi_rresp, 2'b00);
    d = s_axi_rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    csr_rd(a, d);
    chk(tag, d, exp);
  endtask

  // lat = cycles from AC handshake edge to first cycle crvalid is seen high.
  task automatic do_snoop(input logic [43:0] a, input logic [3:0] s, input int hold,
                          output int lat, output logic [4:0] resp);
    int n = 0;
    @(negedge clk_100MHz);
    acaddr = a; acsnoop = s; acvalid = 1;
    while (!acready && n < 100) begin @(negedge clk_100MHz); n++; end
    chk("ac_handshake_timeout", n < 100, 1'b1);
    @(negedge clk_100MHz);
    acvalid = 0;
    lat = 0;
    while (!crvalid && lat < 300) begin @(negedge clk_100MHz); lat++; end
    resp = crresp;
    for (int i = 0; i < hold; i++) begin
      chk("hold_crvalid", crvalid, 1'b1);
      chk("hold_crresp", crresp, resp);
      chk("hold_acready", acready, 1'b0);
      @(negedge clk_100MHz);
    end
    crready = 1;
    @(negedge clk_100MHz);
    crready = 0;
    chk("cr_done_crvalid", crvalid, 1'b0);
    chk("cr_done_acready", acready, 1'b1);
  endtask

  function automatic bit model_attack(input logic [31:0] c, input logic [31:0] acs,
                                      input logic [31:0] b, input logic [31:0] sz,
                                      input logic [43:0] a, input logic [3:0] s, input bit st0);
    int unsigned tst = (c >> 1) & 15;
    int unsigned fn  = (c >> 5) & 15;
    longint unsigned lo = b, hi = longint'(b) + longint'(sz), av = a;
    bit snoop_ok = !c[14] || (s == acs[3:0]);
    bit addr_ok  = !c[15] || (av < 64'h1_0000_0000 && av >= lo && av < hi);
    return c[0] && tst == 1 && snoop_ok && addr_ok &&
           ((fn == 0 && c[16] && !st0) || (fn == 1 && c[17]));
  endfunction

  task automatic leak_check(input string tag, input logic [31:0] base, input int exp_ars);
    logic [31:0] d;
    int n = 0;
    csr_wr(6'h10, base);
    csr_wr(6'h14, 32'h0);
    csr_wr(6'h00, 32'h1);
    #100ns;
    csr_wr(6'h00, 32'h0);
    d = 0;
    while (!d[1] && n < 60) begin csr_rd(6'h04, d); n++; end
    chk({tag, "_status"}, d, 32'h2);
    chk({tag, "_ar_count"}, ar_count, exp_ars);
    chk({tag, "_araddr"}, ar_addr_seen, base & 32'hFFFF_FFFC);
    chk({tag, "_arlen"}, ar_len_seen, 8'd3);
    chk({tag, "_arsize"}, ar_size_seen, 3'd2);
    chk({tag, "_arburst"}, ar_burst_seen, 2'b01);
    for (int i = 0; i < 4; i++)
      rd_chk({tag, "_rdata"}, 6'(6'h18 + 4 * i), mem[((base >> 2) + i) & 63]);
  endtask

  initial begin
    int lat, dly, kind, off;
    logic [4:0]  resp;
    logic [31:0] d, m_ctrl, m_delay, m_acsn, m_base, m_size, old_rd1;
    logic [43:0] a;
    logic [3:0]  s;
    longint      al;
    bit          m_st0, m_st1, atk;

    repeat (3) @(negedge clk_100MHz);
    chk("rst_acready", acready, 1'b1);
    chk("rst_crvalid", crvalid, 1'b0);
    chk("rst_crresp", crresp, 5'd0);
    chk("rst_m_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_m_rready", m_axi_rready, 1'b0);
    chk("rst_bvalid", s_axi_bvalid, 1'b0);
    chk("rst_rvalid", s_axi_rvalid, 1'b0);
    reset = 0;
    for (int i = 0; i < 10; i++) rd_chk("rst_csr", 6'(4 * i), 32'h0);
    rd_chk("unmapped_rd", 6'h3C, 32'h0);

    csr_wr(6'h10, 32'hFFFF_FFFF);
    csr_wr(6'h10, 32'h1234_5678, 4'b0101);
    rd_chk("wstrb_merge", 6'h10, 32'hFF34_FF78);

    leak_check("leak0", 32'h2, 1);
    csr_rd(6'h18, old_rd1);
    csr_wr(6'h18, ~old_rd1);
    rd_chk("ro_write_ignored", 6'h18, old_rd1);
    csr_wr(6'h04, 32'h2);
    rd_chk("status_w1c_leak", 6'h04, 32'h0);
    leak_check("leak1", 32'($urandom_range(0, 240)), 2);
    csr_wr(6'h04, 32'h2);

    csr_wr(6'h08, 32'd2);
    csr_wr(6'h00, 32'h0001_0003);
    do_snoop(44'h100, 4'h0, 0, lat, resp);
    chk("osh_first_lat", lat, 3);
    rd_chk("osh_status_set", 6'h04, 32'h1);
    do_snoop(44'h100, 4'h0, 0, lat, resp);
    chk("osh_second_lat", lat, 1);
    csr_wr(6'h04, 32'h1);
    rd_chk("osh_status_clr", 6'h04, 32'h0);
    do_snoop(44'h200, 4'h3, 0, lat, resp);
    chk("osh_rearm_lat", lat, 3);
    csr_wr(6'h04, 32'h1);

    csr_wr(6'h08, 32'd0);
    csr_wr(6'h00, 32'h0002_0A23);
    for (int i = 0; i < 3; i++) begin
      do_snoop(44'($urandom), 4'($urandom), (i == 1) ? 5 : 0, lat, resp);
      chk("con_lat", lat, 1);
      chk("con_resp", resp, 5'd5);
    end
    csr_wr(6'h00, 32'h0002_0A22);
    do_snoop(44'h40, 4'h0, 0, lat, resp);
    chk("en0_resp", resp, 5'd0);

    csr_wr(6'h0C, 32'h1);
    csr_wr(6'h00, 32'h0002_4A23);
    do_snoop(44'h40, 4'h0, 0, lat, resp);
    chk("acflt_miss_resp", resp, 5'd0);
    do_snoop(44'h40, 4'h1, 0, lat, resp);
    chk("acflt_hit_resp", resp, 5'd5);

    csr_wr(6'h10, 32'h10);
    csr_wr(6'h14, 32'h100);
    csr_wr(6'h00, 32'h0002_8A23);
    do_snoop(44'h0, 4'h0, 0, lat, resp);          chk("addr_below", resp, 5'd0);
    do_snoop(44'h110, 4'h0, 0, lat, resp);        chk("addr_end", resp, 5'd0);
    do_snoop(44'h10, 4'h0, 0, lat, resp);         chk("addr_base", resp, 5'd5);
    do_snoop(44'h10F, 4'h0, 0, lat, resp);        chk("addr_last", resp, 5'd5);
    do_snoop(44'h1_0000_0010, 4'h0, 0, lat, resp); chk("addr_high", resp, 5'd0);

    m_st0 = 0; m_st1 = 0;
    for (int it = 0; it < 60; it++) begin
      m_ctrl = $urandom;
      m_ctrl[0]   = ($urandom_range(0, 5) != 0);
      m_ctrl[4:1] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(2, 3)) : 4'd1;
      m_ctrl[8:5] = 4'($urandom_range(0, 2));
      dly     = $urandom_range(0, 4);
      m_delay = dly;
      m_acsn  = $urandom;
      m_base  = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 4096);
      m_size  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 512);
      kind    = $urandom_range(0, 5);
      off     = (kind == 1) ? -1 : (kind == 2) ? 0 : (kind == 3) ? int'(m_size) - 1 :
                (kind == 4) ? int'(m_size) : int'($urandom_range(0, 600));
      al      = longint'(m_base) + longint'(off);
      a       = (kind == 0 || al < 0) ? {12'($urandom_range(0, 1)), 32'($urandom)} : 44'(al);
      s       = ($urandom_range(0, 1) == 1) ? m_acsn[3:0] : 4'($urandom);
      if (it % 9 == 8) begin csr_wr(6'h04, 32'h1); m_st0 = 0; end
      csr_wr(6'h08, m_delay);
      csr_wr(6'h0C, m_acsn);
      csr_wr(6'h10, m_base);
      csr_wr(6'h14, m_size);
      csr_wr(6'h00, m_ctrl);
      atk = model_attack(m_ctrl, m_acsn, m_base, m_size, a, s, m_st0);
      do_snoop(a, s, $urandom_range(0, 3), lat, resp);
      chk("rnd_lat", lat, atk ? dly + 1 : 1);
      chk("rnd_resp", resp, atk ? m_ctrl[13:9] : 5'd0);
      if (atk && m_ctrl[8:5] == 0) m_st0 = 1;
      rd_chk("rnd_status", 6'h04, {30'd0, m_st1, m_st0});
      if (it % 20 == 0) rd_chk("rnd_ctrl_rb", 6'h00, m_ctrl);
    end

    csr_wr(6'h08, 32'd20);
    csr_wr(6'h00, 32'h0002_0A23);
    @(negedge clk_100MHz);
    acaddr = 44'h80; acvalid = 1;
    @(negedge clk_100MHz);
    acvalid = 0;
    repeat (3) @(negedge clk_100MHz);
    chk("mid_wait_acready", acready, 1'b0);
    reset = 1;
    @(negedge clk_100MHz);
    chk("rst_wait_acready", acready, 1'b1);
    chk("rst_wait_crvalid", crvalid, 1'b0);
    chk("rst_wait_crresp", crresp, 5'd0);
    reset = 0;
    rd_chk("rst_wait_ctrl", 6'h00, 32'h0);
    rd_chk("rst_wait_delay", 6'h08, 32'h0);
    do_snoop(44'h80, 4'h0, 0, lat, resp);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_resp", resp, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
